// File: rtl/storage_ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// storage_ram_arbiter_pkg
// Shared types and constants for the StorageRam arbiter:
//   arb_state_e : arbiter FSM states (idle, owned by port 0, owned by port 1)
//   owner_t     : 1-bit requester tag (0 = port 0, 1 = port 1)
//   RD_LATENCY  : cycles from read grant to rvalid/rdata
//   tie_pick()  : winner selection when no burst or handover rule applies
// ---------------------------------------------------------------------------
package storage_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    typedef logic owner_t;

    localparam int RD_LATENCY = 2;

    // A single requester always wins; on a tie the preferred port wins.
    function automatic owner_t tie_pick(input logic req0, input logic req1, input owner_t pref);
        owner_t w;
        if (req0 && req1) begin
            w = pref;
        end else if (req0) begin
            w = 1'b0;
        end else begin
            w = 1'b1;
        end
        return w;
    endfunction

endpackage

// File: rtl/storage_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// storage_ram_arbiter_if
// Requester-side bus of the StorageRam arbiter.
//   req/lock/we/addr/wdata per port : requester -> arbiter
//   gnt/rvalid per port, rdata      : arbiter -> requesters
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface storage_ram_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  req0;
    logic                  req1;
    logic                  lock0;
    logic                  lock1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata
    );

    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata
    );
endinterface

// File: rtl/storage_ram_rd_pipe.sv
// ---------------------------------------------------------------------------
// storage_ram_rd_pipe
// Read-response pipeline: tags each granted read with its owner, waits for
// the RAM's one-cycle q latency, then registers q into the shared rdata and
// pulses the owner's rvalid (RD_LATENCY = 2 cycles after the grant).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   rd_start_i          : a read is granted this cycle
//   rd_owner_i          : owner of that read
//   ram_q_i             : RAM output, valid the cycle after the address
//   rvalid0_o/rvalid1_o : one-cycle read-valid pulse per port
//   rdata_o             : registered read data, holds when no rvalid
// ---------------------------------------------------------------------------
module storage_ram_rd_pipe
    import storage_ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_start_i,
    input  owner_t                rd_owner_i,
    input  logic [DATA_WIDTH-1:0] ram_q_i,
    output logic                  rvalid0_o,
    output logic                  rvalid1_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic                  s1_valid_q, s1_valid_d;
    owner_t                s1_owner_q, s1_owner_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Next-state for the tag stage and the response stage.
    always_comb begin
        s1_valid_d = rd_start_i;
        s1_owner_d = rd_owner_i;
        rvalid0_d  = s1_valid_q & ~s1_owner_q;
        rvalid1_d  = s1_valid_q & s1_owner_q;
        if (s1_valid_q) begin
            rdata_d = ram_q_i;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Pipeline registers; reset drops any read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_owner_q <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_owner_q <= s1_owner_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;
    assign rdata_o   = rdata_q;

endmodule

// File: rtl/storage_ram_arbiter.sv
// ---------------------------------------------------------------------------
// storage_ram_arbiter
// Shares one single-port StorageRam between two requesters. Per-cycle
// arbitration with optional burst lock (up to MAX_BURST consecutive grants),
// forwards the winner's access to the RAM, returns read data after 2 cycles.
// Build option: STORAGE_ARB_RR_EN -- round-robin on ties (winner is the port
// that was not granted last); undefined -> port 0 wins all ties.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   bus (slave)        : requester handshake, grants, read responses
//   ram_addr/data/we   : to RAM; addr/data hold last value when idle
//   ram_q              : from RAM, valid the cycle after the address
// ---------------------------------------------------------------------------
module storage_ram_arbiter
    import storage_ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    storage_ram_arbiter_if.slave  bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  lock_q, lock_d;
    owner_t                last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
    logic [DATA_WIDTH-1:0] data_hold_q, data_hold_d;

    logic                  gnt_any_s;
    logic                  gnt_s;
    owner_t                winner_s;
    owner_t                cur_s;
    owner_t                pref_s;
    logic                  owned_s;
    logic                  req_cur_s;
    logic                  req_oth_s;
    logic                  win_we_s;
    logic [ADDR_WIDTH-1:0] win_addr_s;
    logic [DATA_WIDTH-1:0] win_data_s;

    // Grant decision and FSM / burst-counter next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lock_d    = lock_q;
        last_d    = last_q;
        gnt_any_s = 1'b0;
        winner_s  = last_q;
`ifdef STORAGE_ARB_RR_EN
        pref_s    = ~last_q;
`else
        pref_s    = 1'b0;
`endif
        case (state_q)
            ST_OWN0: begin
                owned_s = 1'b1;
                cur_s   = 1'b0;
            end
            ST_OWN1: begin
                owned_s = 1'b1;
                cur_s   = 1'b1;
            end
            default: begin
                owned_s = 1'b0;
                cur_s   = 1'b0;
            end
        endcase
        req_cur_s = cur_s ? bus.req1 : bus.req0;
        req_oth_s = cur_s ? bus.req0 : bus.req1;

        if (!(bus.req0 || bus.req1)) begin
            gnt_any_s = 1'b0;
        end else if (owned_s && req_cur_s && lock_q && (cnt_q < MAX_CNT)) begin
            // Locked burst continues.
            gnt_any_s = 1'b1;
            winner_s  = cur_s;
        end else if (owned_s && (cnt_q == MAX_CNT) && req_oth_s) begin
            // Burst limit reached: the waiting port must get a turn.
            gnt_any_s = 1'b1;
            winner_s  = ~cur_s;
        end else begin
            gnt_any_s = 1'b1;
            winner_s  = tie_pick(bus.req0, bus.req1, pref_s);
        end

        if (gnt_any_s) begin
            state_d = winner_s ? ST_OWN1 : ST_OWN0;
            lock_d  = winner_s ? bus.lock1 : bus.lock0;
            last_d  = winner_s;
            if (owned_s && (winner_s == cur_s)) begin
                // Consecutive grant; wraps to 1 when the owner keeps going past the limit.
                cnt_d = (cnt_q == MAX_CNT) ? ONE_CNT : (cnt_q + ONE_CNT);
            end else begin
                cnt_d = ONE_CNT;
            end
        end else begin
            state_d = ST_IDLE;
            lock_d  = 1'b0;
            last_d  = last_q;
            cnt_d   = {CNT_W{1'b0}};
        end
    end

    // Reset gates the grant so every output is quiet while rst_n is low.
    assign gnt_s      = gnt_any_s & rst_n;
    assign bus.gnt0   = gnt_s & ~winner_s;
    assign bus.gnt1   = gnt_s & winner_s;

    assign win_we_s   = winner_s ? bus.we1    : bus.we0;
    assign win_addr_s = winner_s ? bus.addr1  : bus.addr0;
    assign win_data_s = winner_s ? bus.wdata1 : bus.wdata0;

    assign ram_we     = gnt_s & win_we_s;
    assign ram_addr   = gnt_s ? win_addr_s : addr_hold_q;
    assign ram_data   = gnt_s ? win_data_s : data_hold_q;

    // Remember the last driven RAM address/data for idle cycles.
    always_comb begin
        if (gnt_s) begin
            addr_hold_d = win_addr_s;
            data_hold_d = win_data_s;
        end else begin
            addr_hold_d = addr_hold_q;
            data_hold_d = data_hold_q;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            lock_q      <= 1'b0;
            last_q      <= 1'b1;
            addr_hold_q <= {ADDR_WIDTH{1'b0}};
            data_hold_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_q      <= lock_d;
            last_q      <= last_d;
            addr_hold_q <= addr_hold_d;
            data_hold_q <= data_hold_d;
        end
    end

    storage_ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_start_i (gnt_s & ~win_we_s),
        .rd_owner_i (winner_s),
        .ram_q_i    (ram_q),
        .rvalid0_o  (bus.rvalid0),
        .rvalid1_o  (bus.rvalid1),
        .rdata_o    (bus.rdata)
    );

endmodule
